// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy state encoding
// and the saturation ceiling helper used by the performance counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // All-ones value of a counter of the given width (valid for widths up to 64).
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter that adds 0..3 per cycle ({inc2, inc}) and sticks at
// its all-ones ceiling instead of wrapping.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             inc2,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W+1:0] sum;

    // Two guard bits let the sum exceed the ceiling before it is clamped.
    always_comb begin
        sum        = {2'b00, count_reg} + {{CNT_W{1'b0}}, inc2, inc};
        count_next = (sum > {2'b00, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main (head) register plus skid register under a
// valid/ready handshake, with synchronous flush and stall/flush-drop counters.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 8,
    parameter int CNT_W      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_drops
);

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] main_data_reg;
    logic [CTRL_W-1:0] main_ctrl_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;

    logic       take;
    logic       load_main_in;
    logic       load_main_skid;
    logic       load_skid;
    logic [1:0] drop_count;

    // Handshake flags depend only on the registered state, so in_ready has no
    // combinational path from out_ready.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign take      = out_valid & out_ready;
    assign out_data  = main_data_reg;
    assign out_ctrl  = out_valid ? main_ctrl_reg : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_reg)
            EMPTY: begin
                if (in_valid) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (take && in_valid) begin
                    load_main_in = 1'b1;
                end else if (take) begin
                    state_next = EMPTY;
                end else if (in_valid) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (take) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush discards everything, including a beat offered this cycle.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_reg <= '0;
            main_ctrl_reg <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
        end else if (flush) begin
            main_ctrl_reg <= '0;
            skid_ctrl_reg <= '0;
            if (CLEAR_DATA) begin
                main_data_reg <= '0;
                skid_data_reg <= '0;
            end
        end else begin
            if (load_main_in) begin
                main_data_reg <= in_data;
                main_ctrl_reg <= in_ctrl;
            end else if (load_main_skid) begin
                main_data_reg <= skid_data_reg;
                main_ctrl_reg <= skid_ctrl_reg;
            end
            if (load_skid) begin
                skid_data_reg <= in_data;
                skid_ctrl_reg <= in_ctrl;
            end
        end
    end

    // Beats lost to a flush: held beats not taken this cycle plus any offered beat.
    always_comb begin
        drop_count = 2'd0;
        if (flush) begin
            unique case (state_reg)
                ONE:     drop_count = take ? 2'd0 : 2'd1;
                FULL:    drop_count = take ? 2'd1 : 2'd2;
                default: drop_count = 2'd0;
            endcase
            drop_count = drop_count + {1'b0, in_valid};
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .inc2  (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_count[0]),
        .inc2  (drop_count[1]),
        .count (flush_drops)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: reset, streaming, backpressure,
// flush (with and without take) and counter saturation with a 4-bit counter.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic [CTRL_W-1:0] in_ctrl   = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_drops;

    int                checks    = 0;
    int                failures  = 0;
    logic              hold_pend = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CNT_W      (CNT_W),
        .CLEAR_DATA (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .stall_cycles (stall_cycles),
        .flush_drops  (flush_drops)
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            $display("beat out data=%h ctrl=%h flush=%0b", out_data, out_ctrl, flush);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; also checks that a refused beat is still offered unchanged.
    task automatic tick;
        if (hold_pend)
            chk("proto_hold", {15'b0, in_valid, in_data}, {15'b0, 1'b1, hold_data});
        hold_pend = in_valid & ~in_ready & ~flush & ~rst;
        hold_data = in_data;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_counters", {stall_cycles, flush_drops}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming: one beat per cycle, latency one cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(DATA_W'(16'h11 + i), 8'h01);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_out_data", 32'(out_data), 32'h11 + i);
            chk("stream_out_ctrl", 32'(out_ctrl), 32'h01);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", 32'(out_valid), 32'd0);
        chk("stream_drain_ctrl", 32'(out_ctrl), 32'd0);
        chk("stream_stall", 32'(stall_cycles), 32'd0);

        // Backpressure: A, B fill the stage, C waits upstream
        out_ready = 1'b0;
        push(16'h000A, 8'h02);
        tick();
        chk("bp_head_a", 32'(out_data), 32'h0A);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        push(16'h000B, 8'h02);
        tick();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_stall1", 32'(stall_cycles), 32'd1);
        push(16'h000C, 8'h02);
        tick();
        chk("bp_stall2", 32'(stall_cycles), 32'd2);
        tick();
        chk("bp_stall3", 32'(stall_cycles), 32'd3);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_head", 32'(out_data), 32'h0A);
        chk("bp_hold_ctrl", 32'(out_ctrl), 32'h02);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", 32'(out_data), 32'h0B);
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        chk("bp_stall_frozen", 32'(stall_cycles), 32'd3);
        tick();
        chk("bp_head_c", 32'(out_data), 32'h0C);
        chk("bp_valid_c", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with the stage FULL
        out_ready = 1'b0;
        push(16'h0031, 8'h07);
        tick();
        push(16'h0032, 8'h07);
        tick();
        chk("rstmid_full", 32'(in_ready), 32'd0);
        chk("rstmid_stall", 32'(stall_cycles), 32'd4);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        chk("rstmid_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("rstmid_counters", {stall_cycles, flush_drops}, 32'd0);
        tick();
        rst = 1'b0;

        // Flush in FULL with a beat offered and no take: three drops
        push(16'h0021, 8'h03);
        tick();
        push(16'h0022, 8'h03);
        tick();
        push(16'h0023, 8'h03);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_drops3", 32'(flush_drops), 32'd3);
        chk("flush_stall", 32'(stall_cycles), 32'd2);

        // Flush in ONE while the head beat is taken: no drop
        push(16'h0041, 8'h05);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        chk("ftake_visible", {15'b0, out_valid, out_data}, {15'b0, 1'b1, 16'h0041});
        tick();
        flush = 1'b0;
        chk("ftake_drops", 32'(flush_drops), 32'd3);
        chk("ftake_empty", 32'(out_valid), 32'd0);
        chk("ftake_stall", 32'(stall_cycles), 32'd2);

        // Stall counter saturation
        rst = 1'b1;
        #2;
        rst       = 1'b0;
        out_ready = 1'b0;
        push(16'h0051, 8'h09);
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        chk("sat_stall14", 32'(stall_cycles), 32'd14);
        repeat (6) tick();
        chk("sat_stall15", 32'(stall_cycles), 32'd15);
        chk("sat_head", 32'(out_data), 32'h51);

        // Flush-drop counter saturation (first cycle drops 2, then 1 each)
        push(16'h0060, 8'h01);
        flush = 1'b1;
        tick();
        chk("sat_drops2", 32'(flush_drops), 32'd2);
        repeat (12) tick();
        chk("sat_drops14", 32'(flush_drops), 32'd14);
        repeat (3) tick();
        chk("sat_drops15", 32'(flush_drops), 32'd15);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("sat_end_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
